cycle_tracer: RTL and testbench

- Downstream stage of the Bellman-Ford relaxation container in the FOREX peripheral.
- Starts when the container reports a node that was still relaxed in the extra iteration.
- Walks the container's predecessor memory back far enough to land inside the negative (arbitrage) cycle, then streams that cycle out as a closed sequence of currency node indices.
- Consumers are the frame-buffer writer and the software readback path.

---
 rtl/cycle_tracer_pkg.sv | 19 +
 rtl/cycle_tracer.sv | 174 +++++++++++++++++
 tb/tb_cycle_tracer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cycle_tracer_pkg.sv
// Shared types and sizing constants for the arbitrage cycle tracer.
// Combinational only: no latency.
// No flow control: type and constant definitions only.
package cycle_tracer_pkg;

  // Width of a predecessor pointer field minus one; the node index is one bit wider.
  localparam int PRED_WIDTH    = 2;
  localparam int NODES_DEFAULT = 8;

  // Tracer FSM states, exported so debug/readback logic can decode them.
  typedef enum logic [2:0] {
    TR_IDLE     = 3'd0,
    TR_WALK     = 3'd1,
    TR_EMIT_REQ = 3'd2,
    TR_EMIT     = 3'd3,
    TR_DONE     = 3'd4
  } tracer_state_t;

endpackage

// File: rtl/cycle_tracer.sv
// Walks the predecessor memory into the negative cycle, then streams the cycle as node beats.
// Latency: first beat 2*NODES+1 clocks after start; 3 clocks per further beat plus stall time.
// Backpressure: cyc_valid/cyc_ready; beat held stable while not accepted, no predecessor read until accepted.
module cycle_tracer
  import cycle_tracer_pkg::*;
#(
  parameter int NODES = NODES_DEFAULT,
  parameter int IDX_W = PRED_WIDTH + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [IDX_W-1:0] i_start_node,
  output logic [IDX_W-1:0] o_pred_rd_addr,
  input  logic [IDX_W-1:0] i_pred_rd_data,
  input  logic             i_pred_rd_none,
  output logic             o_cyc_valid,
  input  logic             i_cyc_ready,
  output logic [IDX_W-1:0] o_cyc_node,
  output logic             o_cyc_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_no_cycle
);

  localparam int STEP_W = $clog2(NODES + 1);
  localparam int BEAT_W = $clog2(NODES + 2);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(NODES);
  // A non-head node arriving once this many beats are out could only close past NODES+1 beats.
  localparam logic [BEAT_W-1:0] BEAT_LIMIT = BEAT_W'(NODES);

  tracer_state_t     r_state,     w_state_nxt;
  logic              r_phase,     w_phase_nxt;   // 0: address cycle, 1: data cycle
  logic [STEP_W-1:0] r_step,      w_step_nxt;
  logic [BEAT_W-1:0] r_beat,      w_beat_nxt;
  logic [IDX_W-1:0]  r_head,      w_head_nxt;
  logic [IDX_W-1:0]  r_addr,      w_addr_nxt;
  logic              r_cyc_vld,   w_cyc_vld_nxt;
  logic [IDX_W-1:0]  r_cyc_node,  w_cyc_node_nxt;
  logic              r_cyc_last,  w_cyc_last_nxt;
  logic              r_no_cycle,  w_no_cycle_nxt;

  // State and datapath registers; reset abandons any trace in flight.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= TR_IDLE;
      r_phase    <= 1'b0;
      r_step     <= '0;
      r_beat     <= '0;
      r_head     <= '0;
      r_addr     <= '0;
      r_cyc_vld  <= 1'b0;
      r_cyc_node <= '0;
      r_cyc_last <= 1'b0;
      r_no_cycle <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_step     <= w_step_nxt;
      r_beat     <= w_beat_nxt;
      r_head     <= w_head_nxt;
      r_addr     <= w_addr_nxt;
      r_cyc_vld  <= w_cyc_vld_nxt;
      r_cyc_node <= w_cyc_node_nxt;
      r_cyc_last <= w_cyc_last_nxt;
      r_no_cycle <= w_no_cycle_nxt;
    end
  end

  // Next-state and next-register logic for the walk and emit phases.
  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_step_nxt     = r_step;
    w_beat_nxt     = r_beat;
    w_head_nxt     = r_head;
    w_addr_nxt     = r_addr;
    w_cyc_vld_nxt  = r_cyc_vld;
    w_cyc_node_nxt = r_cyc_node;
    w_cyc_last_nxt = r_cyc_last;
    w_no_cycle_nxt = r_no_cycle;

    case (r_state)
      TR_IDLE: begin
        if (i_start) begin
          w_addr_nxt     = i_start_node;
          w_step_nxt     = '0;
          w_phase_nxt    = 1'b0;
          w_no_cycle_nxt = 1'b0;
          w_state_nxt    = TR_WALK;
        end
      end

      TR_WALK: begin
        if (!r_phase) begin
          // After NODES backward steps the current node must sit on the cycle.
          if (r_step == STEP_LAST) begin
            w_head_nxt     = r_addr;
            w_cyc_node_nxt = r_addr;
            w_cyc_last_nxt = 1'b0;
            w_cyc_vld_nxt  = 1'b1;
            w_beat_nxt     = BEAT_W'(1);
            w_state_nxt    = TR_EMIT;
          end else begin
            w_phase_nxt = 1'b1;
          end
        end else begin
          w_phase_nxt = 1'b0;
          if (i_pred_rd_none) begin
            w_no_cycle_nxt = 1'b1;
            w_state_nxt    = TR_DONE;
          end else begin
            w_addr_nxt = i_pred_rd_data;
            w_step_nxt = r_step + STEP_W'(1);
          end
        end
      end

      TR_EMIT: begin
        if (i_cyc_ready) begin
          w_cyc_vld_nxt = 1'b0;
          if (r_cyc_last) begin
            w_cyc_last_nxt = 1'b0;
            w_no_cycle_nxt = 1'b0;
            w_state_nxt    = TR_DONE;
          end else begin
            w_addr_nxt  = r_cyc_node;
            w_phase_nxt = 1'b0;
            w_state_nxt = TR_EMIT_REQ;
          end
        end
      end

      TR_EMIT_REQ: begin
        if (!r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_phase_nxt = 1'b0;
          // Abort on a broken chain or a walk that cannot close within NODES+1 beats.
          if (i_pred_rd_none ||
              ((i_pred_rd_data != r_head) && (r_beat >= BEAT_LIMIT))) begin
            w_no_cycle_nxt = 1'b1;
            w_state_nxt    = TR_DONE;
          end else begin
            w_cyc_node_nxt = i_pred_rd_data;
            w_cyc_last_nxt = (i_pred_rd_data == r_head);
            w_cyc_vld_nxt  = 1'b1;
            w_beat_nxt     = r_beat + BEAT_W'(1);
            w_state_nxt    = TR_EMIT;
          end
        end
      end

      TR_DONE: begin
        // no_cycle is only meaningful alongside done; clear it on the way out.
        w_no_cycle_nxt = 1'b0;
        w_state_nxt    = TR_IDLE;
      end

      default: begin
        w_state_nxt = TR_IDLE;
      end
    endcase
  end

  assign o_pred_rd_addr = r_addr;
  assign o_cyc_valid    = r_cyc_vld;
  assign o_cyc_node     = r_cyc_node;
  assign o_cyc_last     = r_cyc_last;
  assign o_no_cycle     = r_no_cycle;
  assign o_busy         = (r_state != TR_IDLE);
  assign o_done         = (r_state == TR_DONE);

endmodule

// File: tb/tb_cycle_tracer.sv
// Directed bench for cycle_tracer with a 1-cycle-latency predecessor memory model.
module tb_cycle_tracer;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_start = 1'b0;
  logic [2:0] i_start_node = 3'd0;
  logic [2:0] o_pred_rd_addr;
  logic [2:0] i_pred_rd_data = 3'd0;
  logic       i_pred_rd_none = 1'b0;
  logic       o_cyc_valid;
  logic       i_cyc_ready = 1'b1;
  logic [2:0] o_cyc_node;
  logic       o_cyc_last;
  logic       o_busy;
  logic       o_done;
  logic       o_no_cycle;

  cycle_tracer #(.NODES(8), .IDX_W(3)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_start_node   (i_start_node),
    .o_pred_rd_addr (o_pred_rd_addr),
    .i_pred_rd_data (i_pred_rd_data),
    .i_pred_rd_none (i_pred_rd_none),
    .o_cyc_valid    (o_cyc_valid),
    .i_cyc_ready    (i_cyc_ready),
    .o_cyc_node     (o_cyc_node),
    .o_cyc_last     (o_cyc_last),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_no_cycle     (o_no_cycle)
  );

  always #5 i_clk = ~i_clk;

  // Predecessor memory model: registered read, data valid one cycle after the address.
  logic [2:0] pred_mem [8];
  logic       none_mem [8];
  always @(posedge i_clk) begin
    i_pred_rd_data <= pred_mem[o_pred_rd_addr];
    i_pred_rd_none <= none_mem[o_pred_rd_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Cycle counter, beat collector, ready driver and stall observer.
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int bq_node [$];
  int bq_last [$];
  int last_hs_cyc = 0;
  int done_cyc = 0;
  int stall_budget = 0;
  int stall_used = 0;
  int hold_obs = 0;
  int hold_bad = 0;
  bit held_chk = 1'b0;

  always @(negedge i_clk) begin
    if (held_chk) begin
      hold_obs++;
      if (!(o_cyc_valid === 1'b1 && o_cyc_node === 3'd5)) hold_bad++;
      held_chk = 1'b0;
    end
    if (o_cyc_valid && o_cyc_node == 3'd5 && stall_used < stall_budget) begin
      i_cyc_ready = 1'b0;
      stall_used++;
      held_chk = 1'b1;
    end else begin
      i_cyc_ready = 1'b1;
    end
    if (o_cyc_valid && i_cyc_ready) begin
      bq_node.push_back(int'(o_cyc_node));
      bq_last.push_back(int'(o_cyc_last));
      last_hs_cyc = cyc;
    end
    if (o_done) done_cyc = cyc;
  end

  task automatic load_mem(input int scen);
    for (int i = 0; i < 8; i++) begin
      pred_mem[i] = 3'd0;
      none_mem[i] = 1'b1;
    end
    if (scen == 1) begin
      pred_mem[7] = 3'd6; none_mem[7] = 1'b0;
      pred_mem[6] = 3'd2; none_mem[6] = 1'b0;
      pred_mem[2] = 3'd5; none_mem[2] = 1'b0;
      pred_mem[5] = 3'd3; none_mem[5] = 1'b0;
      pred_mem[3] = 3'd2; none_mem[3] = 1'b0;
    end else if (scen == 4) begin
      pred_mem[4] = 3'd4; none_mem[4] = 1'b0;
    end else if (scen == 5) begin
      pred_mem[1] = 3'd0; none_mem[1] = 1'b0;
    end
  endtask

  // Start a trace; report clocks from the start edge to first valid and to done.
  task automatic run_trace(input string tag, input logic [2:0] node, input int pulse_at,
                           output int lat_v, output int lat_d, output logic nc);
    @(negedge i_clk);
    i_start = 1'b1;
    i_start_node = node;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    lat_v = -1;
    lat_d = -1;
    nc = 1'bx;
    for (int n = 1; n <= 300 && lat_d < 0; n++) begin
      if (n == pulse_at) begin
        i_start = 1'b1;
        i_start_node = 3'd4;
      end
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
      if (o_cyc_valid && lat_v < 0) lat_v = n;
      if (o_done) begin
        lat_d = n;
        nc = o_no_cycle;
      end
    end
    @(posedge i_clk);
    #1;
    check({tag, "_done_pulse_end"}, o_done, 0);
    check({tag, "_busy_after"}, o_busy, 0);
  endtask

  task automatic check_beats(input string tag, input int base, input int n,
                             input int e0, input int e1, input int e2, input int e3);
    int exp_n [4];
    exp_n = '{e0, e1, e2, e3};
    check({tag, "_beat_count"}, bq_node.size() - base, n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_node"}, (base + i < bq_node.size()) ? bq_node[base + i] : -1, exp_n[i]);
      check({tag, "_last"}, (base + i < bq_last.size()) ? bq_last[base + i] : -1,
            (i == n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int lv, ld, base, found;
    logic nc;

    load_mem(1);
    #12;
    check("rst_addr", o_pred_rd_addr, 0);
    check("rst_valid", o_cyc_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_no_cycle", o_no_cycle, 0);
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);

    // 1: basic cycle 2,5,3,2
    base = bq_node.size();
    run_trace("s1", 3'd7, 0, lv, ld, nc);
    check("s1_first_valid", lv, 17);
    check("s1_done_lat", ld, 27);
    check("s1_no_cycle", nc, 0);
    check("s1_done_after_hs", done_cyc - last_hs_cyc, 1);
    check_beats("s1", base, 4, 2, 5, 3, 2);

    // 2: stray start during the walk is ignored
    base = bq_node.size();
    run_trace("s2", 3'd7, 5, lv, ld, nc);
    check("s2_first_valid", lv, 17);
    check("s2_done_lat", ld, 27);
    check_beats("s2", base, 4, 2, 5, 3, 2);

    // 3: three stall cycles on node 5
    base = bq_node.size();
    stall_budget = stall_used + 3;
    run_trace("s3", 3'd7, 0, lv, ld, nc);
    check("s3_done_lat", ld, 30);
    check("s3_hold_obs", hold_obs, 3);
    check("s3_hold_bad", hold_bad, 0);
    check_beats("s3", base, 4, 2, 5, 3, 2);

    // 4: self-loop
    load_mem(4);
    base = bq_node.size();
    run_trace("s4", 3'd4, 0, lv, ld, nc);
    check("s4_first_valid", lv, 17);
    check("s4_done_lat", ld, 21);
    check("s4_no_cycle", nc, 0);
    check_beats("s4", base, 2, 4, 4, 0, 0);

    // 5: broken chain aborts during the walk
    load_mem(5);
    base = bq_node.size();
    run_trace("s5", 3'd1, 0, lv, ld, nc);
    check("s5_no_valid", lv, -1);
    check("s5_done_lat", ld, 4);
    check("s5_no_cycle", nc, 1);
    check("s5_beat_count", bq_node.size() - base, 0);

    // 6: reset during the second beat, then replay
    load_mem(1);
    @(negedge i_clk);
    i_start = 1'b1;
    i_start_node = 3'd7;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      @(negedge i_clk);
      if (o_cyc_valid && o_cyc_node == 3'd5) found = 1;
    end
    check("s6_second_beat_seen", found, 1);
    #1;
    i_reset = 1'b0;
    #1;
    check("s6_rst_addr", o_pred_rd_addr, 0);
    check("s6_rst_valid", o_cyc_valid, 0);
    check("s6_rst_node", o_cyc_node, 0);
    check("s6_rst_last", o_cyc_last, 0);
    check("s6_rst_busy", o_busy, 0);
    check("s6_rst_done", o_done, 0);
    check("s6_rst_no_cycle", o_no_cycle, 0);
    repeat (3) @(posedge i_clk);
    #1;
    check("s6_rst_held_valid", o_cyc_valid, 0);
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("s6_idle_after_release", o_busy, 0);
    base = bq_node.size();
    run_trace("s6", 3'd7, 0, lv, ld, nc);
    check("s6_first_valid", lv, 17);
    check("s6_done_lat", ld, 27);
    check("s6_no_cycle", nc, 0);
    check_beats("s6", base, 4, 2, 5, 3, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
